// File: rtl/timekeeper_pkg.sv
// Shared widths, limits and channel state encoding for the multi-alarm timekeeper.
package timekeeper_pkg;
    localparam int SEC_W      = 6;
    localparam int MIN_W      = 6;
    localparam int HRS_W      = 5;
    localparam int CNT_W      = 4;
    localparam int SEC_MAX    = 59;
    localparam int MIN_MAX    = 59;
    localparam int HRS_MAX_24 = 23;
    localparam int HRS_MAX_12 = 11;

    typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZED} ch_state_t;

    typedef struct packed {
        logic min_adj;
        logic hrs_adj;
        logic toggle;
    } al_cmd_t;

    function automatic logic [HRS_W-1:0] hrs_inc(input logic [HRS_W-1:0] h,
                                                 input logic [HRS_W-1:0] hmax);
        return (h >= hmax) ? '0 : h + 1'b1;
    endfunction
endpackage

// File: rtl/multi_alarm_timekeeper_if.sv
// Control pulses in, time/alarm status out; clk and reset stay outside.
interface multi_alarm_timekeeper_if #(parameter int NUM_ALARMS = 2);
    import timekeeper_pkg::*;

    logic                        sec_tick;
    logic                        buzz_tick;
    logic                        sec_adj;
    logic                        min_adj;
    logic                        hrs_adj;
    logic [1:0]                  al_sel;
    logic                        al_min_adj;
    logic                        al_hrs_adj;
    logic                        al_toggle;
    logic                        snooze;
    logic                        dismiss;
    logic [SEC_W-1:0]            seconds;
    logic [MIN_W-1:0]            minutes;
    logic [HRS_W-1:0]            hours;
    logic [MIN_W*NUM_ALARMS-1:0] al_minutes;
    logic [HRS_W*NUM_ALARMS-1:0] al_hours;
    logic [NUM_ALARMS-1:0]       al_armed;
    logic [NUM_ALARMS-1:0]       al_ringing;
    logic                        buzzer_out;

    modport master (
        output sec_tick, buzz_tick, sec_adj, min_adj, hrs_adj, al_sel,
               al_min_adj, al_hrs_adj, al_toggle, snooze, dismiss,
        input  seconds, minutes, hours, al_minutes, al_hours,
               al_armed, al_ringing, buzzer_out
    );

    modport slave (
        input  sec_tick, buzz_tick, sec_adj, min_adj, hrs_adj, al_sel,
               al_min_adj, al_hrs_adj, al_toggle, snooze, dismiss,
        output seconds, minutes, hours, al_minutes, al_hours,
               al_armed, al_ringing, buzzer_out
    );
endinterface

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time, ring/snooze counters and state machine.
module alarm_channel
    import timekeeper_pkg::*;
#(
    parameter int MODE_24H         = 0,
    parameter int AL_MIN_STEP      = 10,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  al_cmd_t          cmd,
    input  logic             snooze,
    input  logic             dismiss,
    input  logic             min_event,
    input  logic [MIN_W-1:0] cur_min,
    input  logic [HRS_W-1:0] cur_hrs,
    output logic [MIN_W-1:0] al_min,
    output logic [HRS_W-1:0] al_hrs,
    output logic             armed,
    output logic             ringing
);
    localparam logic [HRS_W-1:0] HRS_MAX   = (MODE_24H != 0) ? HRS_W'(HRS_MAX_24) : HRS_W'(HRS_MAX_12);
    localparam logic [MIN_W:0]   STEP      = (MIN_W+1)'(AL_MIN_STEP);
    localparam logic [MIN_W:0]   MIN_LIM   = (MIN_W+1)'(MIN_MAX);
    localparam logic [MIN_W:0]   MIN_WRAP  = (MIN_W+1)'(MIN_MAX + 1);
    localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_TIMEOUT_MIN);
    localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_MIN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    ch_state_t        state_q, state_d;
    logic [CNT_W-1:0] ring_q, ring_d, snz_q, snz_d;
    logic [MIN_W-1:0] amin_q, amin_d;
    logic [HRS_W-1:0] ahrs_q, ahrs_d;
    logic [MIN_W:0]   min_sum, min_wrap;
    logic             hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ring_q  <= '0;
            snz_q   <= '0;
            amin_q  <= '0;
            ahrs_q  <= '0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
            amin_q  <= amin_d;
            ahrs_q  <= ahrs_d;
        end
    end

    // Alarm time edits are independent of the state machine.
    always_comb begin
        min_sum  = {1'b0, amin_q} + STEP;
        min_wrap = min_sum - MIN_WRAP;
        amin_d   = amin_q;
        ahrs_d   = ahrs_q;
        if (cmd.min_adj) begin
            if (min_sum > MIN_LIM) begin
                amin_d = min_wrap[MIN_W-1:0];
                ahrs_d = hrs_inc(ahrs_q, HRS_MAX);
            end else begin
                amin_d = min_sum[MIN_W-1:0];
            end
        end
        if (cmd.hrs_adj) ahrs_d = hrs_inc(ahrs_d, HRS_MAX);
    end

    // Match against the time the clock is moving to on this edge.
    always_comb begin
        hit     = min_event && (cur_min == amin_q) && (cur_hrs == ahrs_q);
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        if (cmd.toggle) begin
            state_d = (state_q == IDLE) ? ARMED : IDLE;
        end else if (dismiss && (state_q == RINGING || state_q == SNOOZED)) begin
            state_d = ARMED;
        end else if (snooze && state_q == RINGING) begin
            state_d = SNOOZED;
            snz_d   = SNZ_LOAD;
        end else if (min_event) begin
            case (state_q)
                ARMED: if (hit) begin
                    state_d = RINGING;
                    ring_d  = RING_LOAD;
                end
                RINGING: begin
                    if (ring_q <= CNT_ONE) begin
                        state_d = ARMED;
                        ring_d  = '0;
                    end else begin
                        ring_d = ring_q - 1'b1;
                    end
                end
                SNOOZED: begin
                    if (snz_q <= CNT_ONE) begin
                        state_d = RINGING;
                        snz_d   = '0;
                        ring_d  = RING_LOAD;
                    end else begin
                        snz_d = snz_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        armed   = (state_q != IDLE);
        ringing = (state_q == RINGING);
        al_min  = amin_q;
        al_hrs  = ahrs_q;
    end
endmodule

// File: rtl/multi_alarm_timekeeper.sv
// Time-of-day counter with adjust inputs, NUM_ALARMS alarm channels and a gated buzzer.
module multi_alarm_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int NUM_ALARMS       = 2,
    parameter int MODE_24H         = 0,
    parameter int AL_MIN_STEP      = 10,
    parameter int SNOOZE_MIN       = 5,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input logic                     clk,
    input logic                     reset_n,
    multi_alarm_timekeeper_if.slave bus
);
    localparam logic [HRS_W-1:0] HRS_MAX   = (MODE_24H != 0) ? HRS_W'(HRS_MAX_24) : HRS_W'(HRS_MAX_12);
    localparam logic [SEC_W-1:0] SEC_MAX_V = SEC_W'(SEC_MAX);
    localparam logic [MIN_W-1:0] MIN_MAX_V = MIN_W'(MIN_MAX);

    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HRS_W-1:0] hrs_q, hrs_d;
    logic             pend_q, pend_d;
    logic             tone_q, buzz_q;
    logic             adj_any, do_tick, min_event;

    logic [NUM_ALARMS-1:0][MIN_W-1:0] ch_min;
    logic [NUM_ALARMS-1:0][HRS_W-1:0] ch_hrs;
    logic [NUM_ALARMS-1:0]            ch_armed, ch_ring;

    // An adjust pulse defers any tick; a tick arriving alongside a pending one
    // keeps the pending bit set so neither is dropped.
    always_comb begin
        adj_any   = bus.sec_adj | bus.min_adj | bus.hrs_adj;
        do_tick   = ~adj_any & (bus.sec_tick | pend_q);
        pend_d    = adj_any ? (pend_q | bus.sec_tick) : (pend_q & bus.sec_tick);
        sec_d     = sec_q;
        min_d     = min_q;
        hrs_d     = hrs_q;
        min_event = 1'b0;
        if (do_tick) begin
            if (sec_q >= SEC_MAX_V) begin
                sec_d     = '0;
                min_event = 1'b1;
                if (min_q >= MIN_MAX_V) begin
                    min_d = '0;
                    hrs_d = hrs_inc(hrs_q, HRS_MAX);
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end else begin
            if (bus.sec_adj) sec_d = '0;
            if (bus.min_adj) min_d = (min_q >= MIN_MAX_V) ? '0 : min_q + 1'b1;
            if (bus.hrs_adj) hrs_d = hrs_inc(hrs_q, HRS_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sec_q  <= '0;
            min_q  <= '0;
            hrs_q  <= '0;
            pend_q <= 1'b0;
            tone_q <= 1'b0;
            buzz_q <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hrs_q  <= hrs_d;
            pend_q <= pend_d;
            if (bus.buzz_tick) tone_q <= ~tone_q;
            buzz_q <= tone_q & (|ch_ring) & ~sec_q[0];
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        al_cmd_t cmd;
        logic    sel;
        assign sel         = (bus.al_sel == 2'(i));
        assign cmd.min_adj = bus.al_min_adj & sel;
        assign cmd.hrs_adj = bus.al_hrs_adj & sel;
        assign cmd.toggle  = bus.al_toggle & sel;

        alarm_channel #(
            .MODE_24H        (MODE_24H),
            .AL_MIN_STEP     (AL_MIN_STEP),
            .SNOOZE_MIN      (SNOOZE_MIN),
            .RING_TIMEOUT_MIN(RING_TIMEOUT_MIN)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .cmd      (cmd),
            .snooze   (bus.snooze),
            .dismiss  (bus.dismiss),
            .min_event(min_event),
            .cur_min  (min_d),
            .cur_hrs  (hrs_d),
            .al_min   (ch_min[i]),
            .al_hrs   (ch_hrs[i]),
            .armed    (ch_armed[i]),
            .ringing  (ch_ring[i])
        );
    end

    assign bus.seconds    = sec_q;
    assign bus.minutes    = min_q;
    assign bus.hours      = hrs_q;
    assign bus.al_minutes = ch_min;
    assign bus.al_hours   = ch_hrs;
    assign bus.al_armed   = ch_armed;
    assign bus.al_ringing = ch_ring;
    assign bus.buzzer_out = buzz_q;
endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Scoreboarded directed bench: a 24h and a 12h instance share one set of input pulses.
module tb_multi_alarm_timekeeper;
    import timekeeper_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    multi_alarm_timekeeper_if #(.NUM_ALARMS(2)) d ();
    multi_alarm_timekeeper_if #(.NUM_ALARMS(2)) t ();

    multi_alarm_timekeeper #(.NUM_ALARMS(2), .MODE_24H(1)) dut24 (.clk(clk), .reset_n(reset_n), .bus(d.slave));
    multi_alarm_timekeeper #(.NUM_ALARMS(2), .MODE_24H(0)) dut12 (.clk(clk), .reset_n(reset_n), .bus(t.slave));

    assign t.sec_tick   = d.sec_tick;
    assign t.buzz_tick  = d.buzz_tick;
    assign t.sec_adj    = d.sec_adj;
    assign t.min_adj    = d.min_adj;
    assign t.hrs_adj    = d.hrs_adj;
    assign t.al_sel     = d.al_sel;
    assign t.al_min_adj = d.al_min_adj;
    assign t.al_hrs_adj = d.al_hrs_adj;
    assign t.al_toggle  = d.al_toggle;
    assign t.snooze     = d.snooze;
    assign t.dismiss    = d.dismiss;

    localparam int F_SEC = 0, F_MIN = 1, F_HRS = 2, F_ARM = 3, F_RING = 4, F_BUZ = 5;
    localparam int F_AMIN0 = 6, F_AHRS0 = 7, F_AMIN1 = 8, F_AHRS1 = 9;
    localparam int T_SEC = 10, T_MIN = 11, T_HRS = 12;

    typedef struct {
        string name;
        int    fld;
        int    val;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic int get(input int f);
        case (f)
            F_SEC:   return int'(d.seconds);
            F_MIN:   return int'(d.minutes);
            F_HRS:   return int'(d.hours);
            F_ARM:   return int'(d.al_armed);
            F_RING:  return int'(d.al_ringing);
            F_BUZ:   return int'(d.buzzer_out);
            F_AMIN0: return int'(d.al_minutes[5:0]);
            F_AHRS0: return int'(d.al_hours[4:0]);
            F_AMIN1: return int'(d.al_minutes[11:6]);
            F_AHRS1: return int'(d.al_hours[9:5]);
            T_SEC:   return int'(t.seconds);
            T_MIN:   return int'(t.minutes);
            T_HRS:   return int'(t.hours);
            default: return -1;
        endcase
    endfunction

    task automatic ex(input string n, input int f, input int v);
        sbq.push_back('{n, f, v});
    endtask

    // Monitor: every output snapshot is compared half a cycle after the edge.
    initial forever begin
        @(negedge clk);
        while (sbq.size() > 0) begin
            exp_t e;
            int   got;
            e   = sbq.pop_front();
            got = get(e.fld);
            n_tests++;
            if (got != e.val) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d", e.name, got, e.val);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        d.sec_tick = 0; d.buzz_tick = 0; d.sec_adj = 0; d.min_adj = 0; d.hrs_adj = 0;
        d.al_min_adj = 0; d.al_hrs_adj = 0; d.al_toggle = 0; d.snooze = 0; d.dismiss = 0;
    endtask

    task automatic hrs_n(input int n);  repeat (n) begin d.hrs_adj = 1;    step(); end endtask
    task automatic min_n(input int n);  repeat (n) begin d.min_adj = 1;    step(); end endtask
    task automatic sec_n(input int n);  repeat (n) begin d.sec_tick = 1;   step(); end endtask
    task automatic ahrs_n(input int n); repeat (n) begin d.al_hrs_adj = 1; step(); end endtask
    task automatic amin_n(input int n); repeat (n) begin d.al_min_adj = 1; step(); end endtask

    // Zero the seconds, then 60 ticks: exactly one minute event.
    task automatic minute_ev();
        d.sec_adj = 1; step();
        sec_n(60);
    endtask

    task automatic do_reset();
        reset_n = 0; step();
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        d.al_sel = 0;
        step();
        step();
        ex("rst_sec", F_SEC, 0); ex("rst_min", F_MIN, 0); ex("rst_hrs", F_HRS, 0);
        ex("rst_arm", F_ARM, 0); ex("rst_ring", F_RING, 0); ex("rst_buz", F_BUZ, 0);
        ex("rst_amin0", F_AMIN0, 0); ex("rst_ahrs0", F_AHRS0, 0); ex("rst_t_hrs", T_HRS, 0);
        reset_n = 1;

        // 12h rollover 11:59:59 -> 00:00:00 (24h instance goes to 12:00:00)
        hrs_n(11); min_n(59); sec_n(59);
        ex("t_pre_hrs", T_HRS, 11); ex("t_pre_min", T_MIN, 59); ex("t_pre_sec", T_SEC, 59);
        d.sec_tick = 1; step();
        ex("t_wrap_hrs", T_HRS, 0); ex("t_wrap_min", T_MIN, 0); ex("t_wrap_sec", T_SEC, 0);
        ex("d_noon_hrs", F_HRS, 12); ex("d_noon_min", F_MIN, 0); ex("d_noon_sec", F_SEC, 0);

        // 24h rollover 23:59:59 -> 00:00:00
        hrs_n(11); min_n(59); sec_n(59);
        ex("d_pre_hrs", F_HRS, 23); ex("d_pre_min", F_MIN, 59); ex("d_pre_sec", F_SEC, 59);
        d.sec_tick = 1; step();
        ex("d_wrap_hrs", F_HRS, 0); ex("d_wrap_min", F_MIN, 0); ex("d_wrap_sec", F_SEC, 0);
        ex("t_wrap2_hrs", T_HRS, 0);

        // tick coinciding with min_adj at 10:20:30
        do_reset();
        hrs_n(10); min_n(20); sec_n(30);
        d.sec_tick = 1; d.min_adj = 1; step();
        ex("pend_min", F_MIN, 21); ex("pend_sec", F_SEC, 30); ex("pend_hrs", F_HRS, 10);
        step();
        ex("pend_sec2", F_SEC, 31); ex("pend_min2", F_MIN, 21);
        d.sec_adj = 1; step();
        ex("secadj_sec", F_SEC, 0); ex("secadj_min", F_MIN, 21);
        d.min_adj = 1; d.hrs_adj = 1; step();
        ex("dual_min", F_MIN, 22); ex("dual_hrs", F_HRS, 11);

        // alarm minute stepping from 03:50
        do_reset();
        d.al_sel = 0;
        ahrs_n(3); amin_n(5);
        ex("al_base_h", F_AHRS0, 3); ex("al_base_m", F_AMIN0, 50);
        for (int k = 0; k < 6; k++) begin
            amin_n(1);
            ex("al_step_h", F_AHRS0, 4); ex("al_step_m", F_AMIN0, k * 10);
        end
        ex("al1_m", F_AMIN1, 0); ex("al1_h", F_AHRS1, 0);
        d.al_sel = 2;
        amin_n(1);
        ex("al_bad_sel_m", F_AMIN0, 50); ex("al_bad_sel_h", F_AHRS0, 4);
        d.al_sel = 1;
        ahrs_n(1);
        ex("al1_hadj", F_AHRS1, 1);

        // alarm 0 at 07:30, ring from 07:29:59
        do_reset();
        d.al_sel = 0;
        ahrs_n(7); amin_n(3);
        d.al_toggle = 1; step();
        ex("arm0", F_ARM, 1);
        hrs_n(7); min_n(29); sec_n(59);
        ex("pre_ring", F_RING, 0); ex("pre_ring_sec", F_SEC, 59);
        d.sec_tick = 1; step();
        ex("ring0", F_RING, 1); ex("ring0_min", F_MIN, 30); ex("ring0_hrs", F_HRS, 7);
        d.buzz_tick = 1; step();
        ex("buz_tone_lag", F_BUZ, 0);
        step();
        ex("buz_even", F_BUZ, 1);
        d.sec_tick = 1; step();
        ex("buz_sec1_lag", F_BUZ, 1); ex("sec1", F_SEC, 1);
        step();
        ex("buz_odd", F_BUZ, 0);
        d.sec_tick = 1; step();
        step();
        ex("buz_even2", F_BUZ, 1);
        d.buzz_tick = 1; step();
        step();
        ex("buz_tone_off", F_BUZ, 0);
        d.buzz_tick = 1; step();
        step();
        ex("buz_tone_on", F_BUZ, 1);

        // snooze, five minute events, then dismiss
        d.snooze = 1; step();
        ex("snz_ring", F_RING, 0); ex("snz_arm", F_ARM, 1);
        step();
        ex("snz_buz", F_BUZ, 0);
        repeat (4) minute_ev();
        ex("snz4_ring", F_RING, 0); ex("snz4_min", F_MIN, 34);
        minute_ev();
        ex("snz5_ring", F_RING, 1); ex("snz5_min", F_MIN, 35);
        step();
        ex("snz5_buz", F_BUZ, 1);
        d.dismiss = 1; step();
        ex("dis_ring", F_RING, 0); ex("dis_arm", F_ARM, 1);
        step();
        ex("dis_buz", F_BUZ, 0);

        // channel 1 at 07:40 times out after ten minute events
        d.al_sel = 1;
        ahrs_n(7); amin_n(4);
        d.al_toggle = 1; step();
        ex("arm1", F_ARM, 3);
        repeat (4) minute_ev();
        ex("ch1_pre", F_RING, 0);
        minute_ev();
        ex("ch1_ring", F_RING, 2); ex("ch1_min", F_MIN, 40);
        repeat (9) minute_ev();
        ex("ch1_still", F_RING, 2);
        minute_ev();
        ex("ch1_tmo_ring", F_RING, 0); ex("ch1_tmo_arm", F_ARM, 3); ex("ch1_tmo_min", F_MIN, 50);
        minute_ev();
        ex("ch1_noretrig", F_RING, 0);
        d.al_toggle = 1; step();
        ex("ch1_off", F_ARM, 1);

        // channel 0 moved to 08:00, ring, then reset
        d.al_sel = 0;
        amin_n(3);
        ex("al0_h8", F_AHRS0, 8); ex("al0_m0", F_AMIN0, 0);
        repeat (8) minute_ev();
        ex("ch0_pre8", F_RING, 0);
        minute_ev();
        ex("ch0_ring8", F_RING, 1); ex("ch0_hrs8", F_HRS, 8);
        step();
        ex("ch0_buz8", F_BUZ, 1);
        reset_n = 0; step();
        ex("mr_sec", F_SEC, 0); ex("mr_min", F_MIN, 0); ex("mr_hrs", F_HRS, 0);
        ex("mr_arm", F_ARM, 0); ex("mr_ring", F_RING, 0); ex("mr_buz", F_BUZ, 0);
        ex("mr_amin0", F_AMIN0, 0); ex("mr_ahrs0", F_AHRS0, 0);
        ex("mr_amin1", F_AMIN1, 0); ex("mr_ahrs1", F_AHRS1, 0);
        reset_n = 1;

        repeat (3) @(negedge clk);
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
